crc16_frame_seq: RTL and testbench

Frame-level sequencer that owns one crc16_engine instance through its port interface. Passes a LoraLite byte stream through and feeds every byte to the engine, honouring engine busy. Generate mode appends the 2-byte CRC16-MODBUS trailer, low byte first. Check mode verifies that the residue over payload+CRC is 0x0000. Sits between the frame buffer/DMA and the radio or UART byte path.

---
 rtl/crc16_frame_seq.sv | 205 ++++++++++++++++++++
 tb/tb_crc16_frame_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_seq.sv
// Frame sequencer that drives an external bit-serial crc16_engine: passes bytes through,
// appends (generate) or verifies (check) the CRC16-MODBUS trailer. Optional stats: CRC_SEQ_STATS_EN.
module crc16_frame_seq #(
  parameter int MAX_LEN = 255,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             check_mode,
  input  logic             abort,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             crc_init,
  output logic [7:0]       crc_data,
  output logic             crc_valid,
  input  logic [15:0]      crc_out,
  input  logic             crc_busy,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [15:0]      result_crc,
  output logic [LEN_W-1:0] frame_len,
  output logic [7:0]       stat_ok_cnt,
  output logic [7:0]       stat_bad_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ACCEPT, S_WAIT, S_APP_LO, S_APP_HI, S_DONE
  } state_e;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_CHK = LEN_W'(3);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             len_err_q, len_err_d;
  logic [15:0]      result_crc_q, result_crc_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             fin_len_err;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    last_d       = last_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    crc_ok_d     = crc_ok_q;
    len_err_d    = len_err_q;
    result_crc_d = result_crc_q;
    frame_len_d  = frame_len_q;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_data       = 8'h00;
    m_last       = 1'b0;
    crc_init     = 1'b0;
    crc_data     = 8'h00;
    crc_valid    = 1'b0;
    fin_len_err  = ovf_q | (mode_q & (cnt_q < MIN_CHK));

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          state_d = S_INIT;
          mode_d  = check_mode;
        end
      end
      S_INIT: begin
        crc_init = 1'b1;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        last_d   = 1'b0;
        state_d  = S_ACCEPT;
      end
      S_ACCEPT: begin
        m_data  = s_data;
        m_valid = s_valid;
        m_last  = mode_q & s_last;
        s_ready = m_ready;
        if (s_valid && m_ready) begin
          crc_valid = 1'b1;
          crc_data  = s_data;
          last_d    = s_last;
          state_d   = S_WAIT;
          // Bytes past MAX_LEN still flow; only the count saturates and the overflow is remembered.
          if (cnt_q == MAX_CNT) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_WAIT: begin
        if (!crc_busy) begin
          if (!last_q)     state_d = S_ACCEPT;
          else if (mode_q) state_d = S_DONE;
          else             state_d = S_APP_LO;
        end
      end
      S_APP_LO: begin
        m_valid = 1'b1;
        m_data  = crc_out[7:0];
        if (m_ready) state_d = S_APP_HI;
      end
      S_APP_HI: begin
        m_valid = 1'b1;
        m_data  = crc_out[15:8];
        m_last  = 1'b1;
        if (m_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the state decoded above, including a handshake in ACCEPT.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      crc_init  = 1'b1;
      crc_valid = 1'b0;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
    end

    // Results are registered on entry to DONE so they line up with the done pulse.
    done_d = (state_d == S_DONE);
    if (done_d) begin
      result_crc_d = crc_out;
      frame_len_d  = cnt_q;
      len_err_d    = fin_len_err;
      crc_ok_d     = !fin_len_err && (!mode_q || crc_out == 16'h0000);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      last_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      len_err_q    <= 1'b0;
      result_crc_q <= 16'h0000;
      frame_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      last_q       <= last_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      crc_ok_q     <= crc_ok_d;
      len_err_q    <= len_err_d;
      result_crc_q <= result_crc_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign done       = done_q;
  assign crc_ok     = crc_ok_q;
  assign len_err    = len_err_q;
  assign result_crc = result_crc_q;
  assign frame_len  = frame_len_q;

`ifdef CRC_SEQ_STATS_EN
  logic [7:0] stat_ok_q, stat_ok_d, stat_bad_q, stat_bad_d;

  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_bad_d = stat_bad_q;
    if (done_d) begin
      if (crc_ok_d && stat_ok_q != 8'hFF)               stat_ok_d  = stat_ok_q + 8'd1;
      if (mode_q && !crc_ok_d && stat_bad_q != 8'hFF)   stat_bad_d = stat_bad_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ok_q  <= 8'h00;
      stat_bad_q <= 8'h00;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_bad_q <= stat_bad_d;
    end
  end

  assign stat_ok_cnt  = stat_ok_q;
  assign stat_bad_cnt = stat_bad_q;
`else
  assign stat_ok_cnt  = 8'h00;
  assign stat_bad_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_crc16_frame_seq.sv
// Directed bench for crc16_frame_seq with a bit-serial CRC16-MODBUS engine model (8 busy cycles per byte).
module tb_crc16_frame_seq;
  localparam int MAX_LEN = 255;
  localparam int LEN_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             check_mode = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             m_ready = 1'b0;
  logic             s_ready, m_valid, m_last;
  logic [7:0]       m_data;
  logic             crc_init, crc_valid;
  logic [7:0]       crc_data;
  logic [15:0]      crc_out;
  logic             crc_busy;
  logic             done, crc_ok, len_err;
  logic [15:0]      result_crc;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       stat_ok_cnt, stat_bad_cnt;

  always #5 clk = ~clk;

  // Engine model: latch byte on data_valid, then shift one bit per cycle for 8 cycles.
  logic [15:0] eng_crc;
  logic [7:0]  eng_sh;
  logic [3:0]  eng_cnt;
  logic        eng_busy;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic [15:0] t;
    t = c ^ {15'b0, b};
    return t[0] ? ((t >> 1) ^ 16'hA001) : (t >> 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_crc <= 16'hFFFF; eng_sh <= 8'h00; eng_cnt <= 4'd0; eng_busy <= 1'b0;
    end else if (crc_init) begin
      eng_crc <= 16'hFFFF; eng_cnt <= 4'd0; eng_busy <= 1'b0;
    end else if (crc_valid && !eng_busy) begin
      eng_sh <= crc_data; eng_cnt <= 4'd8; eng_busy <= 1'b1;
    end else if (eng_busy) begin
      eng_crc <= crc_bit(eng_crc, eng_sh[0]);
      eng_sh  <= eng_sh >> 1;
      eng_cnt <= eng_cnt - 4'd1;
      if (eng_cnt == 4'd1) eng_busy <= 1'b0;
    end
  end

  assign crc_out  = eng_crc;
  assign crc_busy = eng_busy;

  crc16_frame_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .check_mode(check_mode), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .crc_init(crc_init), .crc_data(crc_data), .crc_valid(crc_valid),
    .crc_out(crc_out), .crc_busy(crc_busy),
    .done(done), .crc_ok(crc_ok), .len_err(len_err), .result_crc(result_crc),
    .frame_len(frame_len), .stat_ok_cnt(stat_ok_cnt), .stat_bad_cnt(stat_bad_cnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;
  int done_cnt = 0;
  int exp_ok = 0;
  int exp_bad = 0;
  logic [7:0] tx_buf [0:299];
  logic [7:0] ob[$];
  logic       ol[$];
  int         hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin ob.push_back(m_data); ol.push_back(m_last); end
      if (s_valid && s_ready) hs_cyc.push_back(cyc);
      if (crc_valid && crc_busy) viol++;
      if (crc_valid && crc_init) viol++;
      if (done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic load_std();
    for (int i = 0; i < 9; i++) tx_buf[i] = 8'h31 + 8'(i);
    tx_buf[9]  = 8'h37;
    tx_buf[10] = 8'h4B;
  endtask

  task automatic clear_mon();
    ob.delete(); ol.delete(); hs_cyc.delete();
  endtask

  task automatic send_frame(input logic mode, input int n, input bit with_last);
    bit hs;
    int w;
    check_mode = mode;
    m_ready    = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_data  = tx_buf[i];
      s_valid = 1'b1;
      s_last  = with_last && (i == n - 1);
      hs = 1'b0;
      w  = 0;
      while (!hs && w < 40) begin
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk); #1;
        w++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL send_handshake: byte %0d not accepted within 40 cycles", i);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    int w;
    got = 1'b0;
    w   = 0;
    while (!got && w < 600) begin
      @(negedge clk);
      got = done;
      w++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL wait_done: got no done pulse, required one within 600 cycles"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_last, crc_init, crc_valid, done, crc_ok, len_err} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b required 00000000",
        {s_ready, m_valid, m_last, crc_init, crc_valid, done, crc_ok, len_err});
    end
    checks++;
    if ({m_data, crc_data, result_crc, frame_len, stat_ok_cnt, stat_bad_cnt} !== 48'h0) begin
      errors++; $display("FAIL reset_buses: m_data=%h crc_data=%h result=%h len=%0d ok=%0d bad=%0d, required all 0",
        m_data, crc_data, result_crc, frame_len, stat_ok_cnt, stat_bad_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_generate();
    int bad;
    load_std(); clear_mon();
    send_frame(1'b0, 9, 1'b1);
    wait_done();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL gen_done_width: done=%b one cycle after pulse, required 0", done); end
    checks++;
    if (ob.size() != 11) begin errors++; $display("FAIL gen_out_count: got %0d bytes required 11", ob.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 11; i++) if (ob[i] !== tx_buf[i] || ol[i] !== (i == 10)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL gen_out_stream: %0d bytes/last flags wrong, required 31..39,37,4B last on 4B", bad); end
    end
    checks++;
    if (result_crc !== 16'h4B37) begin errors++; $display("FAIL gen_result_crc: got %h required 4b37", result_crc); end
    checks++;
    if ({crc_ok, len_err} !== 2'b10) begin errors++; $display("FAIL gen_ok_lenerr: got ok=%b len_err=%b required 1 0", crc_ok, len_err); end
    checks++;
    if (frame_len !== 8'd9) begin errors++; $display("FAIL gen_frame_len: got %0d required 9", frame_len); end
    bad = 0;
    for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 10) bad++;
    checks++;
    if (hs_cyc.size() != 9 || bad != 0) begin
      errors++; $display("FAIL gen_throughput: %0d handshakes, %0d gaps not 10 cycles; required 9 handshakes 10 apart", hs_cyc.size(), bad);
    end
    exp_ok++;
  endtask

  task automatic test_check_good();
    int bad;
    load_std(); clear_mon();
    send_frame(1'b1, 11, 1'b1);
    wait_done();
    bad = 0;
    if (ob.size() != 11) bad = 99;
    else for (int i = 0; i < 11; i++) if (ob[i] !== tx_buf[i] || ol[i] !== (i == 10)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL chk_passthrough: %0d errors, %0d bytes; required 11 bytes last on 4B", bad, ob.size()); end
    checks++;
    if (result_crc !== 16'h0000) begin errors++; $display("FAIL chk_residue: got %h required 0000", result_crc); end
    checks++;
    if ({crc_ok, len_err} !== 2'b10) begin errors++; $display("FAIL chk_ok_lenerr: got ok=%b len_err=%b required 1 0", crc_ok, len_err); end
    checks++;
    if (frame_len !== 8'd11) begin errors++; $display("FAIL chk_frame_len: got %0d required 11", frame_len); end
    exp_ok++;
  endtask

  task automatic test_check_bad();
    load_std(); clear_mon();
    tx_buf[4] = 8'h36;
    send_frame(1'b1, 11, 1'b1);
    wait_done();
    checks++;
    if (result_crc === 16'h0000) begin errors++; $display("FAIL bad_residue: got %h required nonzero", result_crc); end
    checks++;
    if ({crc_ok, len_err} !== 2'b00) begin errors++; $display("FAIL bad_ok_lenerr: got ok=%b len_err=%b required 0 0", crc_ok, len_err); end
    exp_bad++;
  endtask

  task automatic test_backpressure();
    int  w;
    bit  hold_ok;
    load_std(); clear_mon();
    send_frame(1'b0, 9, 1'b1);
    m_ready = 1'b0;
    w = 0;
    while (w < 30) begin
      @(negedge clk);
      if (m_valid) break;
      w++;
    end
    hold_ok = m_valid && (m_data === 8'h37) && !m_last;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!(m_valid && m_data === 8'h37 && !m_last)) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin errors++; $display("FAIL bp_hold: m_valid=%b m_data=%h during stall, required 1 and 37 for 5 cycles", m_valid, m_data); end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done();
    checks++;
    if (ob.size() != 11 || ob[9] !== 8'h37 || ob[10] !== 8'h4B || ol[9] !== 1'b0 || ol[10] !== 1'b1) begin
      errors++; $display("FAIL bp_trailer: %0d bytes, trailer not 37 then 4B(last)", ob.size());
    end
    checks++;
    if (result_crc !== 16'h4B37) begin errors++; $display("FAIL bp_result_crc: got %h required 4b37", result_crc); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL bp_engine_rules: got %0d crc_valid protocol violations required 0", viol); end
    exp_ok++;
  endtask

  task automatic test_short_check();
    clear_mon();
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h00;
    send_frame(1'b1, 2, 1'b1);
    wait_done();
    checks++;
    if ({crc_ok, len_err} !== 2'b01) begin errors++; $display("FAIL short_ok_lenerr: got ok=%b len_err=%b required 0 1", crc_ok, len_err); end
    checks++;
    if (frame_len !== 8'd2) begin errors++; $display("FAIL short_frame_len: got %0d required 2", frame_len); end
    checks++;
    if (ob.size() != 2 || ol[1] !== 1'b1) begin errors++; $display("FAIL short_out: got %0d bytes required 2 with last on second", ob.size()); end
    exp_bad++;
  endtask

  task automatic test_overlength();
    clear_mon();
    for (int i = 0; i <= MAX_LEN; i++) tx_buf[i] = 8'(i);
    send_frame(1'b0, MAX_LEN + 1, 1'b1);
    wait_done();
    checks++;
    if ({crc_ok, len_err} !== 2'b01) begin errors++; $display("FAIL ovl_ok_lenerr: got ok=%b len_err=%b required 0 1", crc_ok, len_err); end
    checks++;
    if (frame_len !== 8'd255) begin errors++; $display("FAIL ovl_frame_len: got %0d required 255", frame_len); end
    checks++;
    if (ob.size() != MAX_LEN + 3) begin errors++; $display("FAIL ovl_out_count: got %0d bytes required %0d", ob.size(), MAX_LEN + 3); end
  endtask

  task automatic test_abort_wait();
    int dc;
    load_std(); clear_mon();
    dc = done_cnt;
    send_frame(1'b0, 4, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if ({crc_init, s_ready, m_valid, crc_valid} !== 4'b1000) begin
      errors++; $display("FAIL abort_wait_cycle: got init/ready/valid/crc_valid=%b required 1000", {crc_init, s_ready, m_valid, crc_valid});
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (crc_init !== 1'b0) begin errors++; $display("FAIL abort_init_pulse: crc_init=%b after abort cycle required 0", crc_init); end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != dc) begin errors++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt - dc); end
    clear_mon();
    send_frame(1'b0, 9, 1'b1);
    wait_done();
    checks++;
    if (result_crc !== 16'h4B37 || crc_ok !== 1'b1) begin
      errors++; $display("FAIL abort_next_frame: got crc=%h ok=%b required 4b37 1", result_crc, crc_ok);
    end
    exp_ok++;
  endtask

  task automatic test_abort_accept();
    int dc;
    dc = done_cnt;
    check_mode = 1'b0; m_ready = 1'b1;
    s_data = 8'h31; s_valid = 1'b1; s_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if ({crc_init, s_ready, m_valid, crc_valid} !== 4'b1000) begin
      errors++; $display("FAIL abort_accept_cycle: got init/ready/valid/crc_valid=%b required 1000", {crc_init, s_ready, m_valid, crc_valid});
    end
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != dc) begin errors++; $display("FAIL abort_accept_no_done: got %0d done pulses required 0", done_cnt - dc); end
  endtask

  task automatic test_stats();
    int eo, eb;
`ifdef CRC_SEQ_STATS_EN
    eo = exp_ok; eb = exp_bad;
`else
    eo = 0; eb = 0;
`endif
    checks++;
    if (stat_ok_cnt !== 8'(eo)) begin errors++; $display("FAIL stat_ok: got %0d required %0d", stat_ok_cnt, eo); end
    checks++;
    if (stat_bad_cnt !== 8'(eb)) begin errors++; $display("FAIL stat_bad: got %0d required %0d", stat_bad_cnt, eb); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL engine_rules_total: got %0d violations required 0", viol); end
  endtask

  task automatic test_reset_mid();
    load_std(); clear_mon();
    send_frame(1'b0, 2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({crc_ok, len_err, done, s_ready, m_valid} !== 5'b0 || result_crc !== 16'h0 || frame_len !== 8'd0 ||
        stat_ok_cnt !== 8'd0 || stat_bad_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset: ok=%b crc=%h len=%0d stats=%0d/%0d required all 0",
        crc_ok, result_crc, frame_len, stat_ok_cnt, stat_bad_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0, 9, 1'b1);
    wait_done();
    checks++;
    if (result_crc !== 16'h4B37) begin errors++; $display("FAIL mid_reset_restart: got %h required 4b37", result_crc); end
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check_good();
    test_check_bad();
    test_backpressure();
    test_short_check();
    test_overlength();
    test_abort_wait();
    test_abort_accept();
    test_stats();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
